// File: rtl/ex_mem_skid_if.sv
// Execute-to-memory handshake bundle for ex_mem_skid_reg: upstream beat, downstream head beat, flush.
// EX_MEM_FWD_EN adds the forwarding taps driven from the head register.
interface ex_mem_skid_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               i_valid;
    logic               o_ready;
    logic [XLEN-1:0]    i_alu_res;
    logic [XLEN-1:0]    i_store_data;
    logic [RADDR_W-1:0] i_rd;
    logic               i_reg_write;
    logic               i_mem_read;
    logic               i_mem_write;
    logic [2:0]         i_funct3;
    logic               i_flush;
    logic               o_valid;
    logic               i_ready;
    logic [XLEN-1:0]    o_alu_res;
    logic [XLEN-1:0]    o_store_data;
    logic [RADDR_W-1:0] o_rd;
    logic               o_reg_write;
    logic               o_mem_read;
    logic               o_mem_write;
    logic [2:0]         o_funct3;
    logic               o_misaligned;
`ifdef EX_MEM_FWD_EN
    logic               o_fwd_valid;
    logic [RADDR_W-1:0] o_fwd_rd;
    logic [XLEN-1:0]    o_fwd_data;

    modport slave (
        input  i_valid, i_alu_res, i_store_data, i_rd, i_reg_write, i_mem_read,
               i_mem_write, i_funct3, i_flush, i_ready,
        output o_ready, o_valid, o_alu_res, o_store_data, o_rd, o_reg_write,
               o_mem_read, o_mem_write, o_funct3, o_misaligned,
               o_fwd_valid, o_fwd_rd, o_fwd_data
    );
    modport master (
        output i_valid, i_alu_res, i_store_data, i_rd, i_reg_write, i_mem_read,
               i_mem_write, i_funct3, i_flush, i_ready,
        input  o_ready, o_valid, o_alu_res, o_store_data, o_rd, o_reg_write,
               o_mem_read, o_mem_write, o_funct3, o_misaligned,
               o_fwd_valid, o_fwd_rd, o_fwd_data
    );
`else
    modport slave (
        input  i_valid, i_alu_res, i_store_data, i_rd, i_reg_write, i_mem_read,
               i_mem_write, i_funct3, i_flush, i_ready,
        output o_ready, o_valid, o_alu_res, o_store_data, o_rd, o_reg_write,
               o_mem_read, o_mem_write, o_funct3, o_misaligned
    );
    modport master (
        output i_valid, i_alu_res, i_store_data, i_rd, i_reg_write, i_mem_read,
               i_mem_write, i_funct3, i_flush, i_ready,
        input  o_ready, o_valid, o_alu_res, o_store_data, o_rd, o_reg_write,
               o_mem_read, o_mem_write, o_funct3, o_misaligned
    );
`endif
endinterface

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with a 2-entry skid buffer (head H drives outputs, skid S absorbs one beat).
// Optional macro EX_MEM_FWD_EN adds combinational forwarding outputs taken from H.
module ex_mem_skid_reg #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input logic          i_clk,
    input logic          i_rst_n,
    ex_mem_skid_if.slave bus
);
    // Handshake: a beat moves when valid and ready are both high at a rising edge;
    // o_ready is registered (high whenever S is empty), upstream must hold its beat until accepted.
    typedef struct packed {
        logic [XLEN-1:0]    alu_res;
        logic [XLEN-1:0]    store_data;
        logic [RADDR_W-1:0] rd;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic [2:0]         funct3;
        logic               misaligned;
    } beat_t;

    beat_t r_h;
    beat_t r_s;
    beat_t w_in;
    logic  r_h_valid;
    logic  r_s_valid;
    logic  r_ready;
    logic  w_in_fire;
    logic  w_out_fire;

    assign w_in_fire  = bus.i_valid & r_ready;
    assign w_out_fire = r_h_valid & bus.i_ready;

    // Capture-time cleanup: rd==0 never writes, misalignment judged once and carried with the beat.
    always_comb begin
        w_in            = '0;
        w_in.alu_res    = bus.i_alu_res;
        w_in.store_data = bus.i_store_data;
        w_in.rd         = bus.i_rd;
        w_in.reg_write  = bus.i_reg_write & (bus.i_rd != '0);
        w_in.mem_read   = bus.i_mem_read;
        w_in.mem_write  = bus.i_mem_write;
        w_in.funct3     = bus.i_funct3;
        w_in.misaligned = (bus.i_mem_read | bus.i_mem_write) &
                          (((bus.i_funct3[1:0] == 2'b01) & bus.i_alu_res[0]) |
                           ((bus.i_funct3[1:0] == 2'b10) & (bus.i_alu_res[1:0] != 2'b00)));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_h       <= '0;
            r_s       <= '0;
            r_h_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_ready   <= 1'b1;
        end else if (bus.i_flush) begin
            r_h_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_ready   <= 1'b1;
        end else if (w_out_fire && r_s_valid) begin
            r_h       <= r_s;
            r_h_valid <= 1'b1;
            r_s_valid <= 1'b0;
            r_ready   <= 1'b1;
        end else if (w_out_fire) begin
            if (w_in_fire) begin
                r_h <= w_in;
            end
            r_h_valid <= w_in_fire;
            r_ready   <= 1'b1;
        end else if (!r_h_valid && w_in_fire) begin
            r_h       <= w_in;
            r_h_valid <= 1'b1;
        end else if (r_h_valid && w_in_fire) begin
            r_s       <= w_in;
            r_s_valid <= 1'b1;
            r_ready   <= 1'b0;
        end
    end

    assign bus.o_ready      = r_ready;
    assign bus.o_valid      = r_h_valid;
    assign bus.o_alu_res    = r_h.alu_res;
    assign bus.o_store_data = r_h.store_data;
    assign bus.o_rd         = r_h.rd;
    assign bus.o_reg_write  = r_h.reg_write;
    assign bus.o_mem_read   = r_h.mem_read;
    assign bus.o_mem_write  = r_h.mem_write;
    assign bus.o_funct3     = r_h.funct3;
    assign bus.o_misaligned = r_h.misaligned;

`ifdef EX_MEM_FWD_EN
    // Loads are excluded: their result is not known until the memory stage returns data.
    assign bus.o_fwd_valid = r_h_valid & r_h.reg_write & ~r_h.mem_read;
    assign bus.o_fwd_rd    = r_h.rd;
    assign bus.o_fwd_data  = r_h.alu_res;
`endif
endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed bench for ex_mem_skid_reg: handshake, skid ordering, capture rules, flush, optional forwarding.
module tb_ex_mem_skid_reg;
  logic clk;
  logic rst_n;
  int n_chk;
  int n_err;
  logic [31:0] exp_q[$];

  ex_mem_skid_if #(.XLEN(32), .RADDR_W(5)) bus ();

  ex_mem_skid_reg #(.XLEN(32), .RADDR_W(5)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver
  task automatic send(input logic v, input logic [31:0] res, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic mw, input logic [2:0] f3);
    bus.i_valid      = v;
    bus.i_alu_res    = res;
    bus.i_store_data = res ^ 32'hFFFF_0000;
    bus.i_rd         = rd;
    bus.i_reg_write  = rw;
    bus.i_mem_read   = mr;
    bus.i_mem_write  = mw;
    bus.i_funct3     = f3;
  endtask

  task automatic idle();
    send(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  // one clock; any beat consumed at this edge is checked against the scoreboard
  task automatic tick();
    logic        fire;
    logic [31:0] got;
    logic [31:0] exp;
    fire = bus.o_valid & bus.i_ready;
    got  = bus.o_alu_res;
    @(posedge clk);
    #1;
    if (fire) begin
      n_chk++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_beat: observed=%0h expected=none", got);
      end
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        chk("beat_order", {32'h0, got}, {32'h0, exp});
        n_chk--;
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_o_valid", bus.o_valid, 1'b0);
    chk("rst_o_ready", bus.o_ready, 1'b1);
    chk("rst_o_alu_res", bus.o_alu_res, 32'h0);
    chk("rst_o_rd", bus.o_rd, 5'd0);
    chk("rst_o_misaligned", bus.o_misaligned, 1'b0);
    rst_n = 1'b1;
    tick();

    // first beat, 1-cycle latency
    bus.i_ready = 1'b1;
    send(1'b1, 32'h0000_1000, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
    exp_q.push_back(32'h0000_1000);
    chk("first_o_ready", bus.o_ready, 1'b1);
    tick();
    chk("first_o_valid", bus.o_valid, 1'b1);
    chk("first_alu_res", bus.o_alu_res, 32'h0000_1000);
    chk("first_rd", bus.o_rd, 5'd5);
    chk("first_reg_write", bus.o_reg_write, 1'b1);
    chk("first_store_data", bus.o_store_data, 32'hFFFF_1000);
    idle();
    tick();
    chk("first_drained", bus.o_valid, 1'b0);

    // skid fill with downstream stalled, then drain in order
    bus.i_ready = 1'b0;
    send(1'b1, 32'h10, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000);
    exp_q.push_back(32'h10);
    tick();
    chk("skid_a_in_h", bus.o_alu_res, 32'h10);
    chk("skid_ready_h_only", bus.o_ready, 1'b1);
    send(1'b1, 32'h20, 5'd2, 1'b1, 1'b0, 1'b0, 3'b000);
    exp_q.push_back(32'h20);
    tick();
    chk("skid_full_ready", bus.o_ready, 1'b0);
    chk("skid_h_stable", bus.o_alu_res, 32'h10);
    send(1'b1, 32'h30, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000);
    exp_q.push_back(32'h30);
    tick();
    chk("skid_c_blocked_res", bus.o_alu_res, 32'h10);
    chk("skid_c_blocked_rd", bus.o_rd, 5'd1);
    chk("skid_c_blocked_ready", bus.o_ready, 1'b0);
    bus.i_ready = 1'b1;
    tick();
    chk("skid_b_to_h", bus.o_alu_res, 32'h20);
    chk("skid_ready_back", bus.o_ready, 1'b1);
    tick();
    chk("skid_c_in_h", bus.o_alu_res, 32'h30);
    chk("skid_c_rd", bus.o_rd, 5'd3);
    idle();
    tick();
    chk("skid_drained", bus.o_valid, 1'b0);

    // sustained throughput
    for (int k = 0; k < 4; k++) begin
      send(1'b1, 32'h100 + k, 5'd4, 1'b1, 1'b0, 1'b0, 3'b010);
      exp_q.push_back(32'h100 + k);
      tick();
      chk("stream_valid", bus.o_valid, 1'b1);
      chk("stream_res", bus.o_alu_res, 32'h100 + k);
      chk("stream_ready", bus.o_ready, 1'b1);
    end
    idle();
    tick();

    // rd==0 suppresses reg_write
    send(1'b1, 32'h44, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000);
    exp_q.push_back(32'h44);
    tick();
    chk("rd0_reg_write", bus.o_reg_write, 1'b0);
    send(1'b1, 32'h48, 5'd9, 1'b1, 1'b0, 1'b0, 3'b000);
    exp_q.push_back(32'h48);
    tick();
    chk("rd9_reg_write", bus.o_reg_write, 1'b1);
    idle();
    tick();

    // misalignment
    send(1'b1, 32'h0000_0102, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010);
    exp_q.push_back(32'h0000_0102);
    tick();
    chk("mis_sw_102", bus.o_misaligned, 1'b1);
    chk("mis_sw_mem_write", bus.o_mem_write, 1'b1);
    send(1'b1, 32'h0000_0102, 5'd6, 1'b1, 1'b1, 1'b0, 3'b001);
    exp_q.push_back(32'h0000_0102);
    tick();
    chk("mis_lh_102", bus.o_misaligned, 1'b0);
    chk("mis_lh_funct3", bus.o_funct3, 3'b001);
    send(1'b1, 32'h0000_0103, 5'd6, 1'b1, 1'b1, 1'b0, 3'b000);
    exp_q.push_back(32'h0000_0103);
    tick();
    chk("mis_lb_103", bus.o_misaligned, 1'b0);
    send(1'b1, 32'h0000_0103, 5'd6, 1'b1, 1'b1, 1'b0, 3'b101);
    exp_q.push_back(32'h0000_0103);
    tick();
    chk("mis_lhu_103", bus.o_misaligned, 1'b1);
    send(1'b1, 32'h0000_0003, 5'd6, 1'b1, 1'b0, 1'b0, 3'b010);
    exp_q.push_back(32'h0000_0003);
    tick();
    chk("mis_alu_not_mem", bus.o_misaligned, 1'b0);
    idle();
    tick();

    // misaligned flag travels from S to H
    bus.i_ready = 1'b0;
    send(1'b1, 32'h0000_0103, 5'd8, 1'b1, 1'b1, 1'b0, 3'b000);
    exp_q.push_back(32'h0000_0103);
    tick();
    send(1'b1, 32'h0000_0106, 5'd8, 1'b1, 1'b1, 1'b0, 3'b010);
    exp_q.push_back(32'h0000_0106);
    tick();
    chk("mis_h_byte", bus.o_misaligned, 1'b0);
    idle();
    bus.i_ready = 1'b1;
    tick();
    chk("mis_s_to_h_res", bus.o_alu_res, 32'h0000_0106);
    chk("mis_s_to_h_flag", bus.o_misaligned, 1'b1);
    tick();

    // flush with H and S full and a beat presented
    bus.i_ready = 1'b0;
    send(1'b1, 32'h50, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000);
    tick();
    send(1'b1, 32'h60, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000);
    tick();
    chk("flush_pre_ready", bus.o_ready, 1'b0);
    bus.i_flush = 1'b1;
    send(1'b1, 32'h70, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000);
    tick();
    chk("flush_o_valid", bus.o_valid, 1'b0);
    chk("flush_o_ready", bus.o_ready, 1'b1);
    bus.i_flush = 1'b0;
    idle();
    bus.i_ready = 1'b1;
    tick();
    tick();
    chk("flush_nothing_left", bus.o_valid, 1'b0);

    // flush discards an accepted-same-cycle beat
    bus.i_flush = 1'b1;
    send(1'b1, 32'h80, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000);
    tick();
    chk("flush_in_discard", bus.o_valid, 1'b0);
    bus.i_flush = 1'b0;
    idle();
    tick();
    chk("flush_in_discard_2", bus.o_valid, 1'b0);

    // flush while the head beat is consumed: that beat counts as delivered
    send(1'b1, 32'h90, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000);
    exp_q.push_back(32'h90);
    tick();
    idle();
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("flush_out_fire_valid", bus.o_valid, 1'b0);

`ifdef EX_MEM_FWD_EN
    bus.i_ready = 1'b0;
    send(1'b1, 32'h200, 5'd7, 1'b1, 1'b1, 1'b0, 3'b010);
    exp_q.push_back(32'h200);
    tick();
    chk("fwd_load_valid", bus.o_fwd_valid, 1'b0);
    bus.i_ready = 1'b1;
    send(1'b1, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0, 1'b0, 3'b000);
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    chk("fwd_alu_valid", bus.o_fwd_valid, 1'b1);
    chk("fwd_alu_rd", bus.o_fwd_rd, 5'd7);
    chk("fwd_alu_data", bus.o_fwd_data, 32'hDEAD_BEEF);
    idle();
    tick();
    chk("fwd_empty_valid", bus.o_fwd_valid, 1'b0);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
